// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - shared states, LFSR taps and default seeds for the AES stimulus sequencer
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    // Four 8-bit tap positions per width, most significant tap first.
    localparam logic [31:0] TAPS_128 = {8'd127, 8'd125, 8'd100, 8'd98};
    localparam logic [31:0] TAPS_192 = {8'd191, 8'd189, 8'd177, 8'd176};
    localparam logic [31:0] TAPS_256 = {8'd255, 8'd253, 8'd250, 8'd245};

    localparam logic [127:0] PT_SEED_DEF   = {4{32'hDEADBEEF}};
    localparam logic [31:0]  KEY_SEED_WORD = 32'hCAFEFEED;

    // Tap position i (0..3) for an LFSR of width w; unknown widths fall back to 128.
    function automatic int lfsr_tap(input int w, input int i);
        logic [31:0] taps;
        case (w)
            192:     taps = TAPS_192;
            256:     taps = TAPS_256;
            default: taps = TAPS_128;
        endcase
        return 32'(taps[8*(3-i) +: 8]);
    endfunction

endpackage

// File: rtl/lfsr_xnor.sv
// rtl/lfsr_xnor.sv - Fibonacci XNOR LFSR with synchronous seed load and advance enable
module lfsr_xnor
    import aes_seq_pkg::*;
#(
    parameter int           W    = 128,
    parameter logic [W-1:0] SEED = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam int T0 = lfsr_tap(W, 0);
    localparam int T1 = lfsr_tap(W, 1);
    localparam int T2 = lfsr_tap(W, 2);
    localparam int T3 = lfsr_tap(W, 3);

    logic fb;

    // XNOR feedback keeps all-zeros legal; all-ones is the lock-up state.
    assign fb = ~(q[T0] ^ q[T1] ^ q[T2] ^ q[T3]);

    // Seed on reset or load, otherwise shift left with feedback into bit 0 when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[W-2:0], fb};
        end
    end

endmodule

// File: rtl/aes_lfsr_sequencer.sv
// rtl/aes_lfsr_sequencer.sv - LFSR stimulus sequencer for AES cores; AES_SEQ_SIG_EN adds a MISR sig output
module aes_lfsr_sequencer
    import aes_seq_pkg::*;
#(
    parameter int               KEY_W    = 128,
    parameter int               AES_LAT  = 21,
    parameter int               KEY_HOLD = 1,
    parameter logic [127:0]     PT_SEED  = PT_SEED_DEF,
    parameter logic [KEY_W-1:0] KEY_SEED = {KEY_W/32{KEY_SEED_WORD}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      num_tests,
    output logic [127:0]     pt,
    output logic [KEY_W-1:0] key,
    output logic             pt_valid,
    input  logic [127:0]     aes_ct,
    output logic             ct_valid,
    output logic [127:0]     ct_data,
    output logic [31:0]      ct_index,
    output logic             busy,
    output logic             done
`ifdef AES_SEQ_SIG_EN
    ,
    output logic [127:0]     sig
`endif
);

    localparam logic [31:0] HOLD_LAST = 32'(KEY_HOLD - 1);

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [AES_LAT-1:0] vpipe;
    logic [31:0]        num_lat;
    logic [31:0]        issued;
    logic [31:0]        hold_cnt;
    logic               accept;
    logic               kill;
    logic               lfsr_load;
    logic               pt_en;
    logic               key_en;

    // abort wins over start even while idle
    assign accept    = (state == IDLE) && start && !abort;
    assign kill      = busy && abort;
    assign lfsr_load = (state == LOAD);
    assign pt_en     = (state == RUN);
    assign key_en    = pt_en && (hold_cnt == HOLD_LAST);
    assign ct_valid  = vpipe[AES_LAT-1];
    assign ct_data   = aes_ct;

    lfsr_xnor #(.W(128), .SEED(PT_SEED)) u_pt_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .en    (pt_en),
        .q     (pt)
    );

    lfsr_xnor #(.W(KEY_W), .SEED(KEY_SEED)) u_key_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .en    (key_en),
        .q     (key)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state handshake outputs.
    always_comb begin
        state_nxt = state;
        pt_valid  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (abort)               state_nxt = IDLE;
                else if (num_lat == '0)  state_nxt = DONE;
                else                     state_nxt = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                pt_valid = 1'b1;
                if (abort)                             state_nxt = IDLE;
                else if (issued == num_lat - 32'd1)    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort)             state_nxt = IDLE;
                else if (vpipe == '0)  state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run length is captured with the accepted start; issue, key-group and result counters restart on LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_lat  <= '0;
            issued   <= '0;
            hold_cnt <= '0;
            ct_index <= '0;
        end else begin
            if (accept) num_lat <= num_tests;
            if (lfsr_load) begin
                issued   <= '0;
                hold_cnt <= '0;
                ct_index <= '0;
            end else begin
                if (pt_en) begin
                    issued   <= issued + 32'd1;
                    hold_cnt <= key_en ? '0 : hold_cnt + 32'd1;
                end
                if (ct_valid) ct_index <= ct_index + 32'd1;
            end
        end
    end

    // Valid pipe mirrors the core latency; abort flushes every in-flight test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else if (kill) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= pt_valid;
            for (int i = 1; i < AES_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

`ifdef AES_SEQ_SIG_EN
    // MISR over returned ciphertexts; holds its final value until the next LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (lfsr_load) begin
            sig <= '0;
        end else if (ct_valid) begin
            sig <= {sig[126:0], sig[127]} ^ ct_data;
        end
    end
`endif

endmodule

// File: tb/tb_aes_lfsr_sequencer.sv
// tb/tb_aes_lfsr_sequencer.sv - self-checking bench for aes_lfsr_sequencer
module tb_aes_lfsr_sequencer;

    localparam int KEY_W = 192;
    localparam int LAT   = 21;
    localparam int KH    = 2;
    localparam logic [255:0] PT_SEED_EXP  = {128'd0, {4{32'hDEADBEEF}}};
    localparam logic [255:0] KEY_SEED_EXP = {64'd0, {6{32'hCAFEFEED}}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [31:0]      num_tests;
    logic [127:0]     pt;
    logic [KEY_W-1:0] key;
    logic             pt_valid;
    logic [127:0]     aes_ct;
    logic             ct_valid;
    logic [127:0]     ct_data;
    logic [31:0]      ct_index;
    logic             busy;
    logic             done;
`ifdef AES_SEQ_SIG_EN
    logic [127:0]     sig;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    aes_lfsr_sequencer #(
        .KEY_W    (KEY_W),
        .AES_LAT  (LAT),
        .KEY_HOLD (KH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .num_tests (num_tests),
        .pt        (pt),
        .key       (key),
        .pt_valid  (pt_valid),
        .aes_ct    (aes_ct),
        .ct_valid  (ct_valid),
        .ct_data   (ct_data),
        .ct_index  (ct_index),
        .busy      (busy),
        .done      (done)
`ifdef AES_SEQ_SIG_EN
        ,
        .sig       (sig)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference LFSR step: shift left, feedback = XNOR of the listed tap bits, truncated to w.
    function automatic logic [255:0] lfsr_step(input logic [255:0] q, input int w);
        int taps[4];
        logic fb;
        logic [255:0] mask;
        case (w)
            192:     taps = '{191, 189, 177, 176};
            256:     taps = '{255, 253, 250, 245};
            default: taps = '{127, 125, 100, 98};
        endcase
        fb   = ~(q[taps[0]] ^ q[taps[1]] ^ q[taps[2]] ^ q[taps[3]]);
        mask = (256'd1 << w) - 256'd1;
        return ((q << 1) | {255'd0, fb}) & mask;
    endfunction

    // One run from start; every cycle is checked against the timeline implied by num and abort_at.
    task automatic do_run(input int num, input int abort_at, input int mid_start, input int pat,
                          output int npt, output int nct, output int ndone);
        int t_done, abort_t, last, j, ct_i;
        logic e_pv, e_cv, e_done, e_busy;
        logic [255:0] ept, ekey;
        logic [127:0] esig;
        npt = 0; nct = 0; ndone = 0;
        j = 0; ct_i = 0;
        ept  = PT_SEED_EXP;
        ekey = KEY_SEED_EXP;
        esig = '0;
        t_done  = (num == 0) ? 2 : num + LAT + 3;
        abort_t = (abort_at > 0) ? 1 + abort_at : 32'h4000_0000;
        last    = (abort_at > 0) ? abort_t + LAT + 4 : t_done + 1;
        for (int t = 0; t <= last; t++) begin
            @(negedge clk);
            e_pv   = (t >= 2) && (t <= num + 1) && (t <= abort_t);
            e_cv   = (t >= 2 + LAT) && (t <= num + 1 + LAT) && (t <= abort_t);
            e_done = (abort_at == 0) && (t == t_done);
            e_busy = (t >= 1) && (t < t_done) && (t <= abort_t);
            start  = (t == 0) || ((mid_start != 0) && (t == 3));
            if (t == 0) num_tests = num;
            if ((mid_start != 0) && (t == 3)) num_tests = num + 7;
            abort  = (t == abort_t);
            if ((pat != 0) && e_cv) aes_ct = 128'd1 << ct_i;
            else                    aes_ct = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("pt_valid", pt_valid, e_pv);
            chk("ct_valid", ct_valid, e_cv);
            chk("done", done, e_done);
            chk("busy", busy, e_busy);
            npt   += pt_valid;
            nct   += ct_valid;
            ndone += done;
            if (t == 1) esig = '0;
            if (e_pv) begin
                chk("pt", pt, ept);
                chk("key", key, ekey);
                j++;
                ept = lfsr_step(ept, 128);
                if (j % KH == 0) ekey = lfsr_step(ekey, KEY_W);
            end
            if (e_cv) begin
                chk("ct_index", ct_index, ct_i);
                chk("ct_data", ct_data, aes_ct);
                esig = {esig[126:0], esig[127]} ^ aes_ct;
                ct_i++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
`ifdef AES_SEQ_SIG_EN
        if (abort_at == 0) chk("sig", sig, esig);
`endif
    endtask

    typedef struct {
        int num;
        int abort_at;
        int mid_start;
        int exp_npt;
        int exp_nct;
        int exp_ndone;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int npt, nct, nd, num, ab;

        vecs.push_back('{1,  0, 0, 1, 1, 1});
        vecs.push_back('{5,  0, 0, 5, 5, 1});
        vecs.push_back('{0,  0, 0, 0, 0, 1});
        vecs.push_back('{10, 4, 0, 4, 0, 0});
        vecs.push_back('{6,  0, 1, 6, 6, 1});
        vecs.push_back('{6,  0, 0, 6, 6, 1});

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_tests = '0; aes_ct = '0;
        repeat (2) @(negedge clk);
        chk("rst_pt", pt, PT_SEED_EXP);
        chk("rst_key", key, KEY_SEED_EXP);
        chk("rst_pt_valid", pt_valid, 1'b0);
        chk("rst_ct_valid", ct_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ct_index", ct_index, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_run(vecs[i].num, vecs[i].abort_at, vecs[i].mid_start, 0, npt, nct, nd);
            chk($sformatf("vec%0d_npt", i), npt, vecs[i].exp_npt);
            chk($sformatf("vec%0d_nct", i), nct, vecs[i].exp_nct);
            chk($sformatf("vec%0d_ndone", i), nd, vecs[i].exp_ndone);
            if (i == 0) chk("pt_after_one", pt, {128'd0, {4{32'hBD5B7DDF}}});
        end

        // start together with abort while idle must not launch a run
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_tests = 32'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        chk("abort_over_start_busy", busy, 1'b0);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1; num_tests = 32'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pt_valid", pt_valid, 1'b0);
        chk("midrst_pt", pt, PT_SEED_EXP);
        chk("midrst_key", key, KEY_SEED_EXP);
        chk("midrst_ct_index", ct_index, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 6; r++) begin
            num = $urandom_range(1, 12);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, num) : 0;
            do_run(num, ab, 0, 0, npt, nct, nd);
            chk("rand_npt", npt, (ab > 0) ? ab : num);
            chk("rand_nct", nct, (ab > 0) ? 0 : num);
            chk("rand_ndone", nd, (ab > 0) ? 0 : 1);
        end

`ifdef AES_SEQ_SIG_EN
        do_run(3, 0, 0, 1, npt, nct, nd);
        chk("sig_walk", sig, 128'h4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
